nasti_lite_write_arbiter: RTL and testbench
===========================================

# nasti_lite_write_arbiter

Round-robin arbiter that shares one NASTI-Lite write port between N_MASTER NASTI-Lite write requesters. It sits in front of the lite-to-NASTI write converter: it serialises AW and W from the granted requester onto the shared channel and routes each B response back to the requester that issued it. It keeps up to MAX_OUTSTANDING writes in flight and returns responses in order.

## Interface

- N_MASTER, 2: number of requesters (≥2)
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered writes (≥1)
- ID_WIDTH, 1: id width, passed through unchanged
- ADDR_WIDTH, 8: address width
- LITE_DATA_WIDTH, 32: data width
- USER_WIDTH, 1: user field width (>0)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_aw_id / s_aw_addr / s_aw_prot / s_aw_qos / s_aw_region / s_aw_user  in  N_MASTER×field width, flattened; requester i at slice i
- s_aw_valid  in  N_MASTER  per-requester AW valid
- s_aw_ready  out  N_MASTER  per-requester AW ready
- s_w_data / s_w_strb / s_w_user  in  N_MASTER×field width  per-requester W payload
- s_w_valid  in  N_MASTER;  s_w_ready  out  N_MASTER
- s_b_id / s_b_resp / s_b_user  out  N_MASTER×field width  B payload, the same value broadcast to every slice
- s_b_valid  out  N_MASTER;  s_b_ready  in  N_MASTER
- m_aw_id, m_aw_addr, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user, m_aw_valid  out;  m_aw_ready  in
- m_w_data, m_w_strb, m_w_user, m_w_valid  out;  m_w_ready  in
- m_b_id, m_b_resp, m_b_user, m_b_valid  in;  m_b_ready  out

## Operation

- Three-state FSM: IDLE, ADDR, DATA. Registers: grant index `gnt`, round-robin pointer `rr`, and the route FIFO of requester indices with depth MAX_OUTSTANDING.
- IDLE:
  - If any s_aw_valid is high and the FIFO count < MAX_OUTSTANDING, latch `gnt` as the first valid requester searching from `rr` upward, with wrap-around, and go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - m_aw_* carries the AW fields of requester `gnt`; m_aw_valid=1.
  - s_aw_ready[gnt]=m_aw_ready; all other bits are 0.
  - On the m_aw handshake: push `gnt` into the FIFO and go to DATA.
- DATA:
  - m_w_* carries the W fields of `gnt`; m_w_valid=s_w_valid[gnt].
  - s_w_ready[gnt]=m_w_ready; all other bits are 0.
  - On the m_w handshake: set rr=(gnt+1) mod N_MASTER and go to IDLE.
- W is never forwarded before its AW. A requester presenting W early is stalled.
- B routing:
  - With head h = FIFO head: s_b_valid[h]=m_b_valid and m_b_ready=s_b_ready[h]; every other s_b_valid bit is 0.
  - Pop on the m_b handshake.
  - With the FIFO empty, m_b_ready=0, so a stray response is held rather than dropped.
- Push and pop in the same cycle are legal; the count is unchanged.
- IDLE admission checks the count. Because only one grant is in flight at a time, a push never overflows.
- m_b_id, m_b_resp and m_b_user pass through unchanged.

## Timing

- Reset values:
  - State IDLE, gnt=0, rr=0, FIFO empty.
  - All s_aw_ready, s_w_ready, s_b_valid, m_aw_valid, m_w_valid and m_b_ready are 0.
- Arbitration costs one cycle: AW first seen in IDLE at cycle t gives m_aw_valid at t+1.
- Best-case throughput is one write per 3 cycles (IDLE, ADDR, DATA).
- B path is combinational, with zero added latency.
- Once asserted, m_aw_valid and m_w_valid stay high with stable payload until the handshake (AXI rule). Grant is never revoked.
- Reset mid-operation returns to the reset state immediately. Any in-flight transaction is abandoned; the surrounding system resets together.

## Structure

- Shared package `nasti_lite_pkg`: FSM state enum (IDLE, ADDR, DATA), resp encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), and a log2 helper for index width.
- Sub-module `lite_write_route_fifo`: synchronous FIFO of $clog2(N_MASTER)-bit entries with push, pop, head, count, full and empty, reset asynchronously to empty.

## Test plan

- Single write: requester 1 sends AW addr=0x40, then W data=0xDEADBEEF with strb=0xF, then m_b resp=0. Required: m_aw_addr=0x40 one cycle after AW valid, m_w_data=0xDEADBEEF, s_b_valid[1]=1 with resp 0, s_b_valid[0]=0.
- Fairness: both requesters hold AW valid continuously for 4 writes. Required: grant order 0,1,0,1.
- Outstanding limit: MAX_OUTSTANDING=2 and B withheld. Required: exactly 2 AW handshakes, then no further m_aw_valid until one B completes.
- In-order routing: requesters 0 then 1 issue writes, then B resp=2 followed by B resp=0. Required: requester 0 gets SLVERR, requester 1 gets OKAY.
- Backpressure: m_aw_ready and m_w_ready low for 5 cycles. Required: payload stable, no extra pushes, no ready leaks to the non-granted requester.
- Reset mid-DATA: assert rstn=0. Required: all valids and readies 0 in the same cycle; after release, FIFO empty and the next grant is requester 0.

Source files
------------

// File: rtl/nasti_lite_write_arbiter_pkg.sv
// nasti_lite_pkg: definitions shared by the NASTI-Lite write arbiter slice.
//   - arb_state_e : arbiter FSM states (IDLE, ADDR, DATA)
//   - RESP_*      : B-channel response encodings
//   - idx_width() : index width helper (never returns less than one bit)
package nasti_lite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Bits needed to index n items; one-item and two-item sets still get one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 2) w = $clog2(n);
        return w;
    endfunction

endpackage

// File: rtl/nasti_lite_write_arbiter_if.sv
// nasti_lite_write_arbiter_if: NASTI-Lite write bus (AW, W, B) for LANES
// requesters, every field flattened with lane i at slice i.
//   modport master : drives AW/W payload+valid and b_ready (the request side)
//   modport slave  : drives aw_ready, w_ready and the B payload+valid
interface nasti_lite_write_arbiter_if #(
    parameter int unsigned LANES      = 1,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [LANES*ID_WIDTH-1:0]   aw_id;
    logic [LANES*ADDR_WIDTH-1:0] aw_addr;
    logic [LANES*3-1:0]          aw_prot;
    logic [LANES*4-1:0]          aw_qos;
    logic [LANES*4-1:0]          aw_region;
    logic [LANES*USER_WIDTH-1:0] aw_user;
    logic [LANES-1:0]            aw_valid;
    logic [LANES-1:0]            aw_ready;

    logic [LANES*DATA_WIDTH-1:0] w_data;
    logic [LANES*STRB_WIDTH-1:0] w_strb;
    logic [LANES*USER_WIDTH-1:0] w_user;
    logic [LANES-1:0]            w_valid;
    logic [LANES-1:0]            w_ready;

    logic [LANES*ID_WIDTH-1:0]   b_id;
    logic [LANES*2-1:0]          b_resp;
    logic [LANES*USER_WIDTH-1:0] b_user;
    logic [LANES-1:0]            b_valid;
    logic [LANES-1:0]            b_ready;

    modport master (
        output aw_id, aw_addr, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready
    );

endinterface

// File: rtl/nasti_lite_write_arbiter_route_fifo.sv
// lite_write_route_fifo: small FIFO of requester indices recording which
// requester owns each accepted-but-unanswered write, oldest at the head.
//   clk, rstn        : clock, asynchronous active-low reset (to empty)
//   i_push/i_push_data : enqueue an index (ignored when full)
//   i_pop            : dequeue the head (ignored when empty)
//   o_head           : current head entry (combinational read)
//   o_count/o_full/o_empty : occupancy
module lite_write_route_fifo
    import nasti_lite_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned DW    = 1,
    localparam int unsigned PW    = idx_width(DEPTH),
    localparam int unsigned CW    = idx_width(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/nasti_lite_write_arbiter.sv
// nasti_lite_write_arbiter: round-robin sharing of one NASTI-Lite write port
// between N_MASTER requesters. AW then W of the granted requester are passed
// to the shared port; B responses are routed back in issue order.
//   clk, rstn : clock, asynchronous active-low reset
//   s_if      : requester side, N_MASTER lanes (slave modport)
//   m_if      : shared downstream port, one lane (master modport)
module nasti_lite_write_arbiter
    import nasti_lite_pkg::*;
#(
    parameter int unsigned N_MASTER        = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned LITE_DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH      = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    nasti_lite_write_arbiter_if.slave  s_if,
    nasti_lite_write_arbiter_if.master m_if
);
    localparam int unsigned IDX_W  = idx_width(N_MASTER);
    localparam int unsigned CNT_W  = idx_width(MAX_OUTSTANDING + 1);
    localparam int unsigned STRB_W = LITE_DATA_WIDTH / 8;

    arb_state_e          r_state, w_state_next;
    logic [IDX_W-1:0]    r_gnt, w_gnt_next;
    logic [IDX_W-1:0]    r_rr, w_rr_next;
    logic [IDX_W-1:0]    w_pick;
    logic [IDX_W-1:0]    w_head;
    logic [IDX_W-1:0]    w_rot_idx [N_MASTER];
    logic [N_MASTER-1:0] w_gnt_oh;
    logic [N_MASTER-1:0] w_head_oh;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_room;

    // Per-lane decode: rotated search order starting at rr, grant and head one-hots.
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_lane
        logic [IDX_W:0] w_sum;
        assign w_sum = {1'b0, r_rr} + (IDX_W+1)'(gi);
        assign w_rot_idx[gi] = (w_sum >= (IDX_W+1)'(N_MASTER))
                             ? IDX_W'(w_sum - (IDX_W+1)'(N_MASTER))
                             : w_sum[IDX_W-1:0];
        assign w_gnt_oh[gi]  = (r_gnt == IDX_W'(gi));
        assign w_head_oh[gi] = !w_fifo_empty && (w_head == IDX_W'(gi));
    end

    // First valid requester at or after rr; scanning backwards lets the
    // nearest offset overwrite the others.
    always_comb begin
        w_pick = r_rr;
        for (int k = int'(N_MASTER) - 1; k >= 0; k--) begin
            if (s_if.aw_valid[w_rot_idx[k]]) w_pick = w_rot_idx[k];
        end
    end

    assign w_room = (w_fifo_count < CNT_W'(MAX_OUTSTANDING));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_rr    <= w_rr_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_rr_next    = r_rr;
        case (r_state)
            IDLE: begin
                if ((|s_if.aw_valid) && w_room) begin
                    w_gnt_next   = w_pick;
                    w_state_next = ADDR;
                end
            end
            ADDR: begin
                if (m_if.aw_ready[0]) w_state_next = DATA;
            end
            DATA: begin
                if (s_if.w_valid[r_gnt] && m_if.w_ready[0]) begin
                    w_rr_next    = (r_gnt == IDX_W'(N_MASTER - 1)) ? '0 : r_gnt + 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: only the granted lane ever sees a ready.
    always_comb begin
        m_if.aw_valid = 1'b0;
        m_if.w_valid  = 1'b0;
        s_if.aw_ready = '0;
        s_if.w_ready  = '0;
        case (r_state)
            ADDR: begin
                m_if.aw_valid = 1'b1;
                s_if.aw_ready = m_if.aw_ready[0] ? w_gnt_oh : '0;
            end
            DATA: begin
                m_if.w_valid = s_if.w_valid[r_gnt];
                s_if.w_ready = m_if.w_ready[0] ? w_gnt_oh : '0;
            end
            default: ;
        endcase
    end

    // Payload of the granted requester; only qualified by the valids above.
    assign m_if.aw_id     = s_if.aw_id[r_gnt*ID_WIDTH +: ID_WIDTH];
    assign m_if.aw_addr   = s_if.aw_addr[r_gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_if.aw_prot   = s_if.aw_prot[r_gnt*3 +: 3];
    assign m_if.aw_qos    = s_if.aw_qos[r_gnt*4 +: 4];
    assign m_if.aw_region = s_if.aw_region[r_gnt*4 +: 4];
    assign m_if.aw_user   = s_if.aw_user[r_gnt*USER_WIDTH +: USER_WIDTH];
    assign m_if.w_data    = s_if.w_data[r_gnt*LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
    assign m_if.w_strb    = s_if.w_strb[r_gnt*STRB_W +: STRB_W];
    assign m_if.w_user    = s_if.w_user[r_gnt*USER_WIDTH +: USER_WIDTH];

    // B path is purely combinational; an empty FIFO holds off a stray response.
    assign s_if.b_id    = {N_MASTER{m_if.b_id}};
    assign s_if.b_resp  = {N_MASTER{m_if.b_resp}};
    assign s_if.b_user  = {N_MASTER{m_if.b_user}};
    assign s_if.b_valid = m_if.b_valid[0] ? w_head_oh : '0;
    assign m_if.b_ready = |(w_head_oh & s_if.b_ready);

    // Admission already guarantees room; the full term only guards the FIFO.
    assign w_push = (r_state == ADDR) && m_if.aw_ready[0] && !w_fifo_full;
    assign w_pop  = m_if.b_valid[0] && m_if.b_ready[0];

    lite_write_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .DW    (IDX_W)
    ) u_route_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push),
        .i_push_data (r_gnt),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule

// File: tb/tb_nasti_lite_write_arbiter.sv
// Testbench for nasti_lite_write_arbiter (2 requesters, 2 outstanding).
// Per-cycle vector table for single write, fairness and in-order B routing,
// then hand-written sequences for outstanding limit, backpressure and reset.
module tb_nasti_lite_write_arbiter;
    import nasti_lite_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nasti_lite_write_arbiter_if #(.LANES(2), .ID_WIDTH(1), .ADDR_WIDTH(8),
                                  .DATA_WIDTH(32), .USER_WIDTH(1)) s_bus ();
    nasti_lite_write_arbiter_if #(.LANES(1), .ID_WIDTH(1), .ADDR_WIDTH(8),
                                  .DATA_WIDTH(32), .USER_WIDTH(1)) m_bus ();

    nasti_lite_write_arbiter #(
        .N_MASTER(2), .MAX_OUTSTANDING(2), .ID_WIDTH(1),
        .ADDR_WIDTH(8), .LITE_DATA_WIDTH(32), .USER_WIDTH(1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .s_if (s_bus.slave),
        .m_if (m_bus.master)
    );

    typedef struct {
        logic [1:0] awv, wv, bre;
        logic       mawr, mwr, mbv;
        logic [1:0] resp;
        logic       e_mawv;
        logic [1:0] e_sawr;
        logic       e_mwv;
        logic [1:0] e_swr;
        logic [1:0] e_sbv;
        logic       e_mbr;
        int         e_g;
    } vec_t;

    localparam int NV = 20;
    vec_t        vec [NV];
    logic [7:0]  addr_tab [2];
    logic [31:0] data_tab [2];
    logic [3:0]  strb_tab [2];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic [1:0] awv, wv, bre, input logic mawr, mwr, mbv,
                                input logic [1:0] resp, input logic e_mawv,
                                input logic [1:0] e_sawr, input logic e_mwv,
                                input logic [1:0] e_swr, e_sbv, input logic e_mbr, input int e_g);
        vec_t v;
        v.awv = awv; v.wv = wv; v.bre = bre; v.mawr = mawr; v.mwr = mwr; v.mbv = mbv;
        v.resp = resp; v.e_mawv = e_mawv; v.e_sawr = e_sawr; v.e_mwv = e_mwv;
        v.e_swr = e_swr; v.e_sbv = e_sbv; v.e_mbr = e_mbr; v.e_g = e_g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] awv, wv, bre, input logic mawr, mwr, mbv,
                         input logic [1:0] resp);
        s_bus.aw_valid = awv;
        s_bus.w_valid  = wv;
        s_bus.b_ready  = bre;
        m_bus.aw_ready = mawr;
        m_bus.w_ready  = mwr;
        m_bus.b_valid  = mbv;
        m_bus.b_resp   = resp;
    endtask

    int   hs;
    logic last_v;
    logic found;

    initial begin
        addr_tab[0] = 8'h20;        addr_tab[1] = 8'h40;
        data_tab[0] = 32'h11111111; data_tab[1] = 32'hDEADBEEF;
        strb_tab[0] = 4'h3;         strb_tab[1] = 4'hF;

        s_bus.aw_id     = 2'b10;
        s_bus.aw_addr   = {addr_tab[1], addr_tab[0]};
        s_bus.aw_prot   = '0;
        s_bus.aw_qos    = '0;
        s_bus.aw_region = '0;
        s_bus.aw_user   = '0;
        s_bus.w_data    = {data_tab[1], data_tab[0]};
        s_bus.w_strb    = {strb_tab[1], strb_tab[0]};
        s_bus.w_user    = '0;
        m_bus.b_id      = 1'b1;
        m_bus.b_user    = 1'b0;
        apply(2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY);

        //            awv    wv     bre    mawr mwr mbv resp         mawv sawr  mwv swr    sbv    mbr g
        vec[0]  = mk(2'b10, 2'b00, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        vec[1]  = mk(2'b10, 2'b10, 2'b11, 1, 1, 0, RESP_OKAY,   1, 2'b10, 0, 2'b00, 2'b00, 0, 1);
        vec[2]  = mk(2'b00, 2'b10, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 1, 2'b10, 2'b00, 1, 1);
        vec[3]  = mk(2'b00, 2'b00, 2'b11, 1, 1, 1, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b10, 1, 0);
        vec[4]  = mk(2'b00, 2'b00, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        vec[5]  = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        vec[6]  = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   1, 2'b01, 0, 2'b00, 2'b00, 0, 0);
        vec[7]  = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 1, 2'b01, 2'b00, 1, 0);
        vec[8]  = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b00, 1, 0);
        vec[9]  = mk(2'b11, 2'b11, 2'b11, 1, 1, 1, RESP_SLVERR, 1, 2'b10, 0, 2'b00, 2'b01, 1, 1);
        vec[10] = mk(2'b11, 2'b11, 2'b11, 1, 1, 1, RESP_OKAY,   0, 2'b00, 1, 2'b10, 2'b10, 1, 1);
        vec[11] = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        vec[12] = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   1, 2'b01, 0, 2'b00, 2'b00, 0, 0);
        vec[13] = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 1, 2'b01, 2'b00, 1, 0);
        vec[14] = mk(2'b11, 2'b11, 2'b11, 1, 1, 1, RESP_EXOKAY, 0, 2'b00, 0, 2'b00, 2'b01, 1, 0);
        vec[15] = mk(2'b11, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   1, 2'b10, 0, 2'b00, 2'b00, 0, 1);
        vec[16] = mk(2'b00, 2'b11, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 1, 2'b10, 2'b00, 1, 1);
        vec[17] = mk(2'b00, 2'b00, 2'b01, 1, 1, 1, RESP_DECERR, 0, 2'b00, 0, 2'b00, 2'b10, 0, 0);
        vec[18] = mk(2'b00, 2'b00, 2'b11, 1, 1, 1, RESP_DECERR, 0, 2'b00, 0, 2'b00, 2'b10, 1, 0);
        vec[19] = mk(2'b00, 2'b00, 2'b11, 1, 1, 0, RESP_OKAY,   0, 2'b00, 0, 2'b00, 2'b00, 0, 0);

        // Reset state
        #2;
        chk("rst_m_aw_valid", m_bus.aw_valid, 0);
        chk("rst_m_w_valid",  m_bus.w_valid,  0);
        chk("rst_s_aw_ready", s_bus.aw_ready, 0);
        chk("rst_s_w_ready",  s_bus.w_ready,  0);
        chk("rst_s_b_valid",  s_bus.b_valid,  0);
        chk("rst_m_b_ready",  m_bus.b_ready,  0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Vector table, one cycle per row
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vec[i].awv, vec[i].wv, vec[i].bre, vec[i].mawr, vec[i].mwr, vec[i].mbv, vec[i].resp);
            #1;
            $display("vec %0d: m_aw_valid=%b s_aw_ready=%b m_w_valid=%b s_w_ready=%b s_b_valid=%b m_b_ready=%b",
                     i, m_bus.aw_valid, s_bus.aw_ready, m_bus.w_valid, s_bus.w_ready,
                     s_bus.b_valid, m_bus.b_ready);
            chk($sformatf("v%0d_m_aw_valid", i), m_bus.aw_valid, vec[i].e_mawv);
            chk($sformatf("v%0d_s_aw_ready", i), s_bus.aw_ready, vec[i].e_sawr);
            chk($sformatf("v%0d_m_w_valid", i),  m_bus.w_valid,  vec[i].e_mwv);
            chk($sformatf("v%0d_s_w_ready", i),  s_bus.w_ready,  vec[i].e_swr);
            chk($sformatf("v%0d_s_b_valid", i),  s_bus.b_valid,  vec[i].e_sbv);
            chk($sformatf("v%0d_m_b_ready", i),  m_bus.b_ready,  vec[i].e_mbr);
            if (vec[i].e_mawv) begin
                chk($sformatf("v%0d_m_aw_addr", i), m_bus.aw_addr, addr_tab[vec[i].e_g]);
                chk($sformatf("v%0d_m_aw_id", i),   m_bus.aw_id,   vec[i].e_g[0]);
            end
            if (vec[i].e_mwv) begin
                chk($sformatf("v%0d_m_w_data", i), m_bus.w_data, data_tab[vec[i].e_g]);
                chk($sformatf("v%0d_m_w_strb", i), m_bus.w_strb, strb_tab[vec[i].e_g]);
            end
            if (vec[i].e_sbv != 2'b00) begin
                chk($sformatf("v%0d_s_b_resp", i), s_bus.b_resp, {vec[i].resp, vec[i].resp});
                chk($sformatf("v%0d_s_b_id", i),   s_bus.b_id,   2'b11);
            end
        end

        // Outstanding limit: B withheld, requester 0 keeps asking
        @(negedge clk);
        apply(2'b00 | 2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY);
        hs = 0;
        last_v = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m_bus.aw_valid[0] && m_bus.aw_ready[0]) hs++;
            last_v = m_bus.aw_valid[0];
            @(negedge clk);
        end
        $display("outstanding: aw handshakes=%0d last m_aw_valid=%b", hs, last_v);
        chk("limit_aw_handshakes", hs, 2);
        chk("limit_aw_held_off",   last_v, 0);
        apply(2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 1'b1, RESP_OKAY);
        #1;
        chk("limit_b_valid", s_bus.b_valid, 2'b01);
        chk("limit_b_ready", m_bus.b_ready, 1);
        @(negedge clk);
        apply(2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY);
        found = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (m_bus.aw_valid[0]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        $display("outstanding: re-admitted after B=%b", found);
        chk("limit_readmit", found, 1);
        @(negedge clk);
        apply(2'b00, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY);
        @(negedge clk);
        apply(2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, RESP_OKAY);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (!m_bus.b_ready[0]) break;
            @(negedge clk);
        end
        $display("outstanding: drained m_b_ready=%b", m_bus.b_ready);
        chk("limit_drained_b_ready", m_bus.b_ready, 0);
        chk("limit_drained_b_valid", s_bus.b_valid, 2'b00);

        // Backpressure: both ask, requester 1 wins (rr=1), ready low 5 cycles
        @(negedge clk);
        apply(2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, RESP_OKAY);
        #1;
        chk("bp_idle_aw_ready", s_bus.aw_ready, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            $display("backpressure aw %0d: m_aw_valid=%b addr=%h s_aw_ready=%b", c,
                     m_bus.aw_valid, m_bus.aw_addr, s_bus.aw_ready);
            chk("bp_aw_valid", m_bus.aw_valid, 1);
            chk("bp_aw_addr",  m_bus.aw_addr,  8'h40);
            chk("bp_aw_ready", s_bus.aw_ready, 2'b00);
            chk("bp_w_stall",  m_bus.w_valid,  0);
        end
        @(negedge clk);
        m_bus.aw_ready = 1'b1;
        #1;
        chk("bp_aw_ready_hs", s_bus.aw_ready, 2'b10);
        @(negedge clk);
        m_bus.aw_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            $display("backpressure w %0d: m_w_valid=%b data=%h s_w_ready=%b", c,
                     m_bus.w_valid, m_bus.w_data, s_bus.w_ready);
            chk("bp_w_valid", m_bus.w_valid, 1);
            chk("bp_w_data",  m_bus.w_data,  32'hDEADBEEF);
            chk("bp_w_ready", s_bus.w_ready, 2'b00);
        end
        @(negedge clk);
        apply(2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, RESP_OKAY);
        #1;
        chk("bp_w_ready_hs", s_bus.w_ready, 2'b10);
        @(negedge clk);
        apply(2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, RESP_OKAY);
        #1;
        chk("bp_b_valid", s_bus.b_valid, 2'b10);
        chk("bp_b_ready", m_bus.b_ready, 1);
        @(negedge clk);
        apply(2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, RESP_OKAY);
        #1;
        chk("bp_single_push", m_bus.b_ready, 0);

        // Reset in DATA: requester 1 granted, W held off, then rstn low
        @(negedge clk);
        apply(2'b10, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, RESP_OKAY);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstd_in_data", m_bus.w_valid, 1);
        @(negedge clk);
        rstn = 1'b0;
        apply(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, RESP_OKAY);
        #1;
        $display("reset in DATA: m_aw_valid=%b m_w_valid=%b s_aw_ready=%b s_w_ready=%b s_b_valid=%b m_b_ready=%b",
                 m_bus.aw_valid, m_bus.w_valid, s_bus.aw_ready, s_bus.w_ready,
                 s_bus.b_valid, m_bus.b_ready);
        chk("rstd_m_aw_valid", m_bus.aw_valid, 0);
        chk("rstd_m_w_valid",  m_bus.w_valid,  0);
        chk("rstd_s_aw_ready", s_bus.aw_ready, 2'b00);
        chk("rstd_s_w_ready",  s_bus.w_ready,  2'b00);
        chk("rstd_s_b_valid",  s_bus.b_valid,  2'b00);
        chk("rstd_m_b_ready",  m_bus.b_ready,  0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rstd_idle_aw_ready", s_bus.aw_ready, 2'b00);
        @(negedge clk);
        #1;
        $display("after reset: s_aw_ready=%b m_b_ready=%b", s_bus.aw_ready, m_bus.b_ready);
        chk("rstd_next_grant_0", s_bus.aw_ready, 2'b01);
        chk("rstd_fifo_empty",   m_bus.b_ready,  0);
        chk("rstd_no_b_valid",   s_bus.b_valid,  2'b00);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
